// File: rtl/noc_input_unit.sv
// noc_input_unit: DEPTH-entry flit FIFO with per-pop credit return and XY route computation on the head flit.
// Optional feature: define NOC_IN_OVF_CHECK_EN to enable the sticky overflow flag on err_o.
module noc_input_unit #(
  parameter int FLIT_W  = 16,
  parameter int COORD_W = 3,
  parameter int DEPTH   = 4,
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_W-1:0]            flit_i,
  input  logic                         valid_i,
  output logic                         incr_o,
  output logic [FLIT_W-1:0]            flit_o,
  output logic [4:0]                   req_o,
  input  logic                         grant_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
  localparam logic [COORD_W-1:0] X_C      = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] Y_C      = COORD_W'(Y_ID);

  logic [FLIT_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]      wrPtr_q, wrPtr_d;
  logic [AW-1:0]      rdPtr_q, rdPtr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               incr_q;
  logic               empty, full, pop, wrEn;
  logic [FLIT_W-1:0]  head;
  logic [COORD_W-1:0] dstX, dstY;
  logic [4:0]         route;

  // A write into a full buffer is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
    pop   = grant_i && !empty;
    wrEn  = valid_i && (!full || pop);
  end

  always_comb begin
    wrPtr_d = wrEn ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
    count_d = count_q;
    if (wrEn && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wrEn) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      incr_q  <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      incr_q  <= pop;
    end
  end

  // Storage is deliberately not reset; flit_o is only meaningful while req_o is non-zero.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrPtr_q] <= flit_i;
    end
  end

  always_comb begin
    head  = mem_q[rdPtr_q];
    dstX  = head[FLIT_W-1 -: COORD_W];
    dstY  = head[FLIT_W-COORD_W-1 -: COORD_W];
    route = '0;
    if (dstX > X_C) begin
      route[2] = 1'b1;
    end else if (dstX < X_C) begin
      route[3] = 1'b1;
    end else if (dstY > Y_C) begin
      route[0] = 1'b1;
    end else if (dstY < Y_C) begin
      route[1] = 1'b1;
    end else begin
      route[4] = 1'b1;
    end
  end

  assign flit_o  = head;
  assign req_o   = empty ? 5'b00000 : route;
  assign count_o = count_q;
  assign incr_o  = incr_q;

`ifdef NOC_IN_OVF_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (valid_i && full && !pop) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
